// File: rtl/rc4_stream_cipher.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module   : rc4_stream_cipher
//  Purpose  : 4-bit RC4 stream cipher core. Owns a 16x4 S-box, runs the key
//             schedule (KSA) on a nibble key, then XORs the keystream onto a
//             nibble data stream. Encryption and decryption are the same
//             operation. One S-box swap is performed per cycle.
//  Ports    :
//    clk         in   1            system clock, all logic on posedge
//    reset       in   1            synchronous, active-high reset
//    start       in   1            pulse: latch key, run INIT+KSA (ignored
//                                  while busy)
//    key         in   4*KEY_LEN    cipher key, nibble n = key[4n+3:4n]
//    busy        out  1            high during INIT/KSA
//    din         in   4            plaintext/ciphertext nibble
//    din_valid   in   1            din qualifier
//    din_ready   out  1            core accepts din this cycle
//    dout        out  4            din ^ keystream nibble
//    dout_valid  out  1            dout qualifier
//    dout_ready  in   1            downstream accepts dout
//  Params   : KEY_LEN  key length in nibbles (1..16)
//  Revision : 1.0  initial release
// ============================================================================
module rc4_stream_cipher #(
    parameter int KEY_LEN = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic [4*KEY_LEN-1:0]   key,
    output logic                   busy,
    input  logic [3:0]             din,
    input  logic                   din_valid,
    output logic                   din_ready,
    output logic [3:0]             dout,
    output logic                   dout_valid,
    input  logic                   dout_ready
);

    // Key-index width; a 1-nibble key still needs a 1-bit (always zero) index.
    localparam int              KX_W      = (KEY_LEN > 1) ? $clog2(KEY_LEN) : 1;
    localparam logic [KX_W-1:0] C_KX_LAST = KX_W'(KEY_LEN - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_INIT = 2'd1;
    localparam logic [1:0] S_KSA  = 2'd2;
    localparam logic [1:0] S_RUN  = 2'd3;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [1:0]            r_state;
    logic [3:0]            r_s [16];
    logic [3:0]            r_i;
    logic [3:0]            r_j;
    logic [KX_W-1:0]       r_kx;
    logic [4*KEY_LEN-1:0]  r_key;
    logic                  r_busy;
    logic [3:0]            r_dout;
    logic                  r_dout_valid;

    // ------------------------------------------------------------------
    // Combinational datapath
    // ------------------------------------------------------------------
    logic [3:0] w_k;          // current key nibble K[kx]
    logic [3:0] w_si_ksa;     // S[i] during KSA
    logic [3:0] w_j_ksa;      // j + S[i] + K[kx]
    logic [3:0] w_i_step;     // i + 1 during RUN
    logic [3:0] w_si_run;     // S[i+1]
    logic [3:0] w_j_run;      // j + S[i+1]
    logic [3:0] w_sj_run;     // S[j'] before the swap
    logic [3:0] w_swap_a;
    logic [3:0] w_swap_b;
    logic [3:0] w_s_swap [16];
    logic [3:0] w_ks_idx;
    logic [3:0] w_ks;
    logic       w_din_ready;
    logic       w_start_ok;
    logic       w_xfer;

    // Key nibble mux. A plain compare loop keeps non-power-of-two KEY_LEN
    // safe: unreachable index values simply select nothing.
    always_comb begin
        w_k = 4'd0;
        for (int n = 0; n < KEY_LEN; n++) begin
            if (r_kx == KX_W'(n)) begin
                w_k = r_key[4*n +: 4];
            end
        end
    end

    assign w_si_ksa = r_s[r_i];
    assign w_j_ksa  = r_j + w_si_ksa + w_k;

    assign w_i_step = r_i + 4'd1;
    assign w_si_run = r_s[w_i_step];
    assign w_j_run  = r_j + w_si_run;
    assign w_sj_run = r_s[w_j_run];

    // The same swap network serves KSA (S[i]<->S[j']) and PRGA
    // (S[i+1]<->S[j']); only the index sources differ.
    assign w_swap_a = (r_state == S_KSA) ? r_i     : w_i_step;
    assign w_swap_b = (r_state == S_KSA) ? w_j_ksa : w_j_run;

    // When a == b the two writes carry the same value, so no special case.
    always_comb begin
        w_s_swap           = r_s;
        w_s_swap[w_swap_a] = r_s[w_swap_b];
        w_s_swap[w_swap_b] = r_s[w_swap_a];
    end

    // S[i]+S[j] is the same before and after the swap, so the index comes
    // from pre-swap values while the read uses the post-swap array.
    assign w_ks_idx = w_si_run + w_sj_run;
    assign w_ks     = w_s_swap[w_ks_idx];

    // ------------------------------------------------------------------
    // Handshake
    // ------------------------------------------------------------------
    assign w_din_ready = (r_state == S_RUN) && (!r_dout_valid || dout_ready);
    assign w_start_ok  = start && ((r_state == S_IDLE) || (r_state == S_RUN));
    // A re-key takes priority: a nibble offered in the same cycle is not consumed.
    assign w_xfer      = din_valid && w_din_ready && !start;

    // ------------------------------------------------------------------
    // Sequential control and datapath
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_i          <= 4'd0;
            r_j          <= 4'd0;
            r_kx         <= '0;
            r_key        <= '0;
            r_busy       <= 1'b0;
            r_dout       <= 4'd0;
            r_dout_valid <= 1'b0;
            for (int n = 0; n < 16; n++) begin
                r_s[n] <= 4'(n);
            end
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_start_ok) begin
                        r_key   <= key;
                        r_busy  <= 1'b1;
                        r_state <= S_INIT;
                    end
                end

                S_INIT: begin
                    for (int n = 0; n < 16; n++) begin
                        r_s[n] <= 4'(n);
                    end
                    r_i     <= 4'd0;
                    r_j     <= 4'd0;
                    r_kx    <= '0;
                    r_state <= S_KSA;
                end

                S_KSA: begin
                    r_s  <= w_s_swap;
                    r_kx <= (r_kx == C_KX_LAST) ? '0 : r_kx + KX_W'(1);
                    if (r_i == 4'd15) begin
                        // Schedule done: PRGA starts from i=j=0.
                        r_i     <= 4'd0;
                        r_j     <= 4'd0;
                        r_busy  <= 1'b0;
                        r_state <= S_RUN;
                    end else begin
                        r_i <= w_i_step;
                        r_j <= w_j_ksa;
                    end
                end

                S_RUN: begin
                    if (w_start_ok) begin
                        // Re-key drops any pending output.
                        r_key        <= key;
                        r_busy       <= 1'b1;
                        r_dout_valid <= 1'b0;
                        r_state      <= S_INIT;
                    end else if (w_xfer) begin
                        r_i          <= w_i_step;
                        r_j          <= w_j_run;
                        r_s          <= w_s_swap;
                        r_dout       <= din ^ w_ks;
                        r_dout_valid <= 1'b1;
                    end else if (r_dout_valid && dout_ready) begin
                        r_dout_valid <= 1'b0;
                    end
                end

                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign busy       = r_busy;
    assign din_ready  = w_din_ready;
    assign dout       = r_dout;
    assign dout_valid = r_dout_valid;

endmodule
`default_nettype wire

// File: tb/tb_rc4_stream_cipher.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module   : tb_rc4_stream_cipher
//  Purpose  : Self-checking bench for rc4_stream_cipher (KEY_LEN = 4) with a
//             behavioural RC4 reference model (array-based KSA/PRGA) and a
//             handshake model for the output register.
//  Revision : 1.0  initial release
// ============================================================================
module tb_rc4_stream_cipher;

    localparam int KL = 4;

    logic            clk = 1'b0;
    logic            reset;
    logic            start;
    logic [4*KL-1:0] key;
    logic            busy;
    logic [3:0]      din;
    logic            din_valid;
    logic            din_ready;
    logic [3:0]      dout;
    logic            dout_valid;
    logic            dout_ready;

    always #5 clk = ~clk;

    rc4_stream_cipher #(.KEY_LEN(KL)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .key        (key),
        .busy       (busy),
        .din        (din),
        .din_valid  (din_valid),
        .din_ready  (din_ready),
        .dout       (dout),
        .dout_valid (dout_valid),
        .dout_ready (dout_ready)
    );

    int vectors     = 0;
    int miscompares = 0;

    // Reference model state
    int         m_s [16];
    int         m_i;
    int         m_j;
    logic       m_valid;
    logic [3:0] m_dout;

    logic [3:0] sbox_t2 [16] = '{4'h0, 4'h6, 4'h3, 4'hE, 4'h9, 4'h2, 4'h1, 4'h8,
                                 4'hF, 4'h5, 4'hD, 4'hC, 4'h7, 4'hB, 4'h4, 4'hA};
    logic [3:0] exp3 [3]    = '{4'h8, 4'hF, 4'h6};

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic m_ksa(input logic [4*KL-1:0] k);
        int j;
        int t;
        for (int n = 0; n < 16; n++) m_s[n] = n;
        j = 0;
        for (int i = 0; i < 16; i++) begin
            j = (j + m_s[i] + int'((k >> (4 * (i % KL))) & 16'hF)) % 16;
            t = m_s[i]; m_s[i] = m_s[j]; m_s[j] = t;
        end
        m_i = 0;
        m_j = 0;
    endtask

    task automatic m_prga(output logic [3:0] ks);
        int t;
        m_i = (m_i + 1) % 16;
        m_j = (m_j + m_s[m_i]) % 16;
        t = m_s[m_i]; m_s[m_i] = m_s[m_j]; m_s[m_j] = t;
        ks = 4'(m_s[(m_s[m_i] + m_s[m_j]) % 16]);
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    // Pulse start, check the pending output drops, count busy cycles.
    task automatic rekey(input logic [4*KL-1:0] k);
        int cnt;
        key       = k;
        start     = 1'b1;
        din_valid = 1'b0;
        step;
        start      = 1'b0;
        dout_ready = 1'b1;
        m_valid    = 1'b0;
        m_ksa(k);
        check("dout_valid_on_start", 8'(dout_valid), 8'd0);
        cnt = 0;
        while (busy === 1'b1 && cnt < 40) begin
            cnt++;
            step;
        end
        check("busy_cycles", 8'(cnt), 8'd17);
        check("din_ready_after_ksa", 8'(din_ready), 8'd1);
    endtask

    // One streaming cycle in RUN: drive, check ready, clock, check output.
    task automatic cyc(input logic dv, input logic [3:0] d, input logic dr);
        logic       exp_rdy;
        logic       xfer;
        logic [3:0] ks;
        din_valid  = dv;
        din        = d;
        dout_ready = dr;
        #1;
        exp_rdy = m_valid ? dr : 1'b1;
        check("din_ready", 8'(din_ready), 8'(exp_rdy));
        xfer = dv && exp_rdy;
        step;
        if (xfer) begin
            m_prga(ks);
            m_dout  = d ^ ks;
            m_valid = 1'b1;
        end else if (m_valid && dr) begin
            m_valid = 1'b0;
        end
        check("dout_valid", 8'(dout_valid), 8'(m_valid));
        check("dout", 8'(dout), 8'(m_dout));
    endtask

    initial begin
        reset      = 1'b1;
        start      = 1'b0;
        key        = '0;
        din        = 4'd0;
        din_valid  = 1'b0;
        dout_ready = 1'b1;
        m_valid    = 1'b0;
        m_dout     = 4'd0;
        step;
        step;
        check("rst_busy", 8'(busy), 8'd0);
        check("rst_dout", 8'(dout), 8'd0);
        check("rst_dout_valid", 8'(dout_valid), 8'd0);
        check("rst_din_ready", 8'(din_ready), 8'd0);
        reset = 1'b0;
        step;
        check("idle_din_ready", 8'(din_ready), 8'd0);

        // KSA timing and resulting S-box for the all-zero key
        rekey('0);
        for (int n = 0; n < 16; n++) check("sbox_key0", 8'(dut.r_s[n]), 8'(sbox_t2[n]));

        // Known keystream 8,F,6
        for (int n = 0; n < 3; n++) begin
            cyc(1'b1, 4'h0, 1'b1);
            check("ks_key0", 8'(dout), 8'(exp3[n]));
        end
        cyc(1'b0, 4'h0, 1'b1);

        // Round trip with a two-cycle downstream stall
        rekey('0);
        cyc(1'b1, 4'h8, 1'b1);
        check("rt0", 8'(dout), 8'd0);
        cyc(1'b1, 4'hF, 1'b0);
        check("rt_hold0", 8'(dout), 8'd0);
        cyc(1'b1, 4'hF, 1'b0);
        check("rt_hold1", 8'(dout), 8'd0);
        cyc(1'b1, 4'hF, 1'b1);
        check("rt1", 8'(dout), 8'd0);
        cyc(1'b1, 4'h6, 1'b1);
        check("rt2", 8'(dout), 8'd0);
        cyc(1'b0, 4'h0, 1'b1);

        // Re-key while an output is pending
        rekey('0);
        cyc(1'b1, 4'h3, 1'b0);
        check("pending_dout", 8'(dout), 8'hB);
        cyc(1'b1, 4'h5, 1'b0);
        rekey('0);
        cyc(1'b1, 4'h0, 1'b1);
        check("restart_ks", 8'(dout), 8'h8);

        // Randomised keys, data and handshakes
        for (int r = 0; r < 3; r++) begin
            rekey(16'($urandom));
            for (int c = 0; c < 60; c++) begin
                cyc(1'($urandom_range(0, 3) != 0), 4'($urandom), 1'($urandom_range(0, 2) != 0));
            end
        end

        // Reset in KSA cycle 8 aborts everything
        key   = '0;
        start = 1'b1;
        step;
        start = 1'b0;
        repeat (8) step;
        reset = 1'b1;
        step;
        check("abort_busy", 8'(busy), 8'd0);
        check("abort_dout", 8'(dout), 8'd0);
        check("abort_dout_valid", 8'(dout_valid), 8'd0);
        check("abort_din_ready", 8'(din_ready), 8'd0);
        for (int n = 0; n < 16; n++) check("abort_sbox", 8'(dut.r_s[n]), 8'(n));
        reset   = 1'b0;
        m_valid = 1'b0;
        m_dout  = 4'd0;
        step;
        rekey('0);
        for (int n = 0; n < 16; n++) check("sbox_after_abort", 8'(dut.r_s[n]), 8'(sbox_t2[n]));
        cyc(1'b1, 4'h0, 1'b1);
        check("ks_after_abort", 8'(dout), 8'h8);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
